// File: rtl/multi_timer.sv
// Multi-channel countdown timer sharing one prescaler; each channel runs one-shot or periodic.
// Optional per-channel warning output is enabled by defining MULTI_TIMER_WARN_EN.
module multi_timer #(
  parameter int CHANNELS   = 2,
  parameter int CLK_HZ     = 50_000_000,
  parameter int TICK_HZ    = 1000,
  parameter int CNT_W      = 16,
  parameter int WARN_TICKS = 100
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CNT_W-1:0]          load_value,
  input  logic [CHANNELS-1:0]       periodic,
  input  logic [CHANNELS-1:0]       start,
  input  logic [CHANNELS-1:0]       stop,
  output logic                      tick,
  output logic [CHANNELS-1:0]       expire,
  output logic [CHANNELS-1:0]       done,
  output logic [CHANNELS-1:0]       busy,
  output logic [CHANNELS*CNT_W-1:0] remaining
`ifdef MULTI_TIMER_WARN_EN
  ,
  output logic [CHANNELS-1:0]       warn
`endif
);

  localparam int PRESCALE = CLK_HZ / TICK_HZ;
  localparam int PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  // Elaboration-time sanity checks on the configuration.
  if (CHANNELS < 1 || PRESCALE < 1 || CNT_W < 1 || WARN_TICKS < 0) begin : g_bad_param
    $error("multi_timer: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  logic [PS_W-1:0] ps_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ps_q <= '0;
    end else if (enable) begin
      ps_q <= (ps_q == PS_LAST) ? '0 : ps_q + 1'b1;
    end
  end

  assign tick = enable && (ps_q == PS_LAST);

  state_t           state_q  [CHANNELS];
  state_t           state_d  [CHANNELS];
  logic [CNT_W-1:0] count_q  [CHANNELS];
  logic [CNT_W-1:0] count_d  [CHANNELS];
  logic [CNT_W-1:0] reload_q [CHANNELS];
  logic [CNT_W-1:0] reload_d [CHANNELS];
  logic             mode_q   [CHANNELS];
  logic             mode_d   [CHANNELS];
  logic [CHANNELS-1:0] expire_d;

  // Per-channel command decode: load > stop > start > tick decrement.
  always_comb begin
    expire_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      state_d[i]  = state_q[i];
      count_d[i]  = count_q[i];
      reload_d[i] = reload_q[i];
      mode_d[i]   = mode_q[i];
      if (load[i]) begin
        count_d[i]  = load_value;
        reload_d[i] = load_value;
        mode_d[i]   = periodic[i];
        state_d[i]  = IDLE;
      end else if (stop[i] && state_q[i] == RUN) begin
        state_d[i] = IDLE;
      end else if (start[i] && state_q[i] == IDLE && count_q[i] != '0) begin
        state_d[i] = RUN;
      end else if (tick && state_q[i] == RUN) begin
        if (count_q[i] > ONE) begin
          count_d[i] = count_q[i] - ONE;
        end else if (count_q[i] == ONE) begin
          expire_d[i] = 1'b1;
          if (mode_q[i]) begin
            count_d[i] = reload_q[i];
          end else begin
            count_d[i] = '0;
            state_d[i] = DONE;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i]  <= IDLE;
        count_q[i]  <= '0;
        reload_q[i] <= '0;
        mode_q[i]   <= 1'b0;
      end
      expire <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i]  <= state_d[i];
        count_q[i]  <= count_d[i];
        reload_q[i] <= reload_d[i];
        mode_q[i]   <= mode_d[i];
      end
      expire <= expire_d;
    end
  end

  // done/busy are decodes of the registered state, so they are glitch-free flop outputs.
  always_comb begin
    done      = '0;
    busy      = '0;
    remaining = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      done[i] = (state_q[i] == DONE);
      busy[i] = (state_q[i] == RUN);
      remaining[i*CNT_W +: CNT_W] = count_q[i];
    end
  end

`ifdef MULTI_TIMER_WARN_EN
  localparam logic [CNT_W-1:0] WARN_CMP =
    (WARN_TICKS >= (2 ** CNT_W)) ? '1 : CNT_W'(WARN_TICKS);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      warn <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        warn[i] <= (state_d[i] == RUN) && (count_d[i] != '0) && (count_d[i] <= WARN_CMP);
      end
    end
  end
`endif

endmodule

// File: tb/tb_multi_timer.sv
// Directed testbench for multi_timer with PRESCALE=10, two 8-bit channels.
// Inputs change 1 time unit after the rising edge; outputs are checked at that same point.
module tb_multi_timer;

  localparam int CNT_W = 8;

  logic             clk;
  logic             rst;
  logic             enable;
  logic [1:0]       load;
  logic [CNT_W-1:0] load_value;
  logic [1:0]       periodic;
  logic [1:0]       start;
  logic [1:0]       stop;
  logic             tick;
  logic [1:0]       expire;
  logic [1:0]       done;
  logic [1:0]       busy;
  logic [2*CNT_W-1:0] remaining;
`ifdef MULTI_TIMER_WARN_EN
  logic [1:0]       warn;
`endif

  int checks;
  int passed;
  int exp0_cnt;
  int tick_seen;

  multi_timer #(
    .CHANNELS(2), .CLK_HZ(10), .TICK_HZ(1), .CNT_W(CNT_W), .WARN_TICKS(2)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .load(load), .load_value(load_value),
    .periodic(periodic), .start(start), .stop(stop), .tick(tick), .expire(expire),
    .done(done), .busy(busy), .remaining(remaining)
`ifdef MULTI_TIMER_WARN_EN
    , .warn(warn)
`endif
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (expire[0] === 1'b1) exp0_cnt++;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Align to a cycle where tick is high; the next edge is a tick edge.
  task automatic sync_tick();
    int n;
    n = 0;
    while (tick !== 1'b1 && n < 20) begin
      cyc(1);
      n++;
    end
    check("sync_tick", {31'd0, tick}, 32'd1);
  endtask

  function automatic logic [CNT_W-1:0] rem(input int ch);
    return remaining[ch*CNT_W +: CNT_W];
  endfunction

  initial begin
    checks = 0; passed = 0; exp0_cnt = 0; tick_seen = 0;
    rst = 1'b0; enable = 1'b0; load = '0; load_value = '0;
    periodic = '0; start = '0; stop = '0;

    // Reset values
    cyc(2);
    check("rst_tick", {31'd0, tick}, 32'd0);
    check("rst_busy", {30'd0, busy}, 32'd0);
    check("rst_done", {30'd0, done}, 32'd0);
    check("rst_expire", {30'd0, expire}, 32'd0);
    check("rst_remaining", {16'd0, remaining}, 32'd0);
    rst = 1'b1; enable = 1'b1;

    // Prescaler: tick on the 10th cycle after release
    cyc(8);
    check("ps_tick_low", {31'd0, tick}, 32'd0);
    cyc(1);
    check("ps_tick_high", {31'd0, tick}, 32'd1);

    // One-shot on ch0 with 3
    sync_tick();
    load = 2'b01; load_value = 8'd3; periodic = 2'b00;
    cyc(1);
    load = 2'b00; start = 2'b01;
    check("os_loaded", {24'd0, rem(0)}, 32'd3);
    check("os_idle", {31'd0, busy[0]}, 32'd0);
    cyc(1);
    start = 2'b00;
    check("os_busy", {31'd0, busy[0]}, 32'd1);
    cyc(8);
    check("os_hold3", {24'd0, rem(0)}, 32'd3);
    cyc(1);
    check("os_rem2", {24'd0, rem(0)}, 32'd2);
    cyc(10);
    check("os_rem1", {24'd0, rem(0)}, 32'd1);
    check("os_no_expire", {31'd0, expire[0]}, 32'd0);
    cyc(10);
    check("os_rem0", {24'd0, rem(0)}, 32'd0);
    check("os_expire", {31'd0, expire[0]}, 32'd1);
    check("os_done", {31'd0, done[0]}, 32'd1);
    check("os_not_busy", {31'd0, busy[0]}, 32'd0);
    cyc(1);
    check("os_expire_1cyc", {31'd0, expire[0]}, 32'd0);
    start = 2'b01;
    cyc(1);
    start = 2'b00;
    check("os_start_in_done", {31'd0, busy[0]}, 32'd0);
    check("os_done_sticky", {31'd0, done[0]}, 32'd1);
    check("os_expire_count", exp0_cnt, 32'd1);

    // Periodic on ch1 with 2: expire every 20 cycles
    sync_tick();
    load = 2'b10; load_value = 8'd2; periodic = 2'b10;
    cyc(1);
    load = 2'b00; start = 2'b10; periodic = 2'b00;
    cyc(1);
    start = 2'b00;
    check("per_busy", {31'd0, busy[1]}, 32'd1);
    cyc(9);
    check("per_rem1", {24'd0, rem(1)}, 32'd1);
    cyc(10);
    check("per_first_expire", {31'd0, expire[1]}, 32'd1);
    check("per_reload", {24'd0, rem(1)}, 32'd2);
    for (int p = 0; p < 4; p++) begin
      cyc(19);
      check("per_gap_quiet", {31'd0, expire[1]}, 32'd0);
      cyc(1);
      check("per_expire", {31'd0, expire[1]}, 32'd1);
      check("per_reload_again", {24'd0, rem(1)}, 32'd2);
      check("per_no_done", {31'd0, done[1]}, 32'd0);
    end
    stop = 2'b10;
    cyc(1);
    stop = 2'b00;
    check("per_stopped", {31'd0, busy[1]}, 32'd0);

    // Pause via enable with ch0 at 5
    sync_tick();
    load = 2'b01; load_value = 8'd5;
    cyc(1);
    load = 2'b00; start = 2'b01;
    check("pause_done_cleared", {31'd0, done[0]}, 32'd0);
    cyc(1);
    start = 2'b00;
    cyc(3);
    enable = 1'b0;
    for (int k = 0; k < 35; k++) begin
      cyc(1);
      if (tick !== 1'b0) tick_seen++;
    end
    check("pause_no_tick", tick_seen, 32'd0);
    check("pause_hold5", {24'd0, rem(0)}, 32'd5);
    check("pause_still_busy", {31'd0, busy[0]}, 32'd1);
    enable = 1'b1;
    cyc(5);
    check("pause_tick_resumes", {31'd0, tick}, 32'd1);
    check("pause_rem5", {24'd0, rem(0)}, 32'd5);
    cyc(1);
    check("pause_rem4", {24'd0, rem(0)}, 32'd4);

    // stop then start resumes from held count
    stop = 2'b01;
    cyc(1);
    stop = 2'b00;
    check("stop_idle", {31'd0, busy[0]}, 32'd0);
    cyc(20);
    check("stop_held", {24'd0, rem(0)}, 32'd4);
    start = 2'b01;
    cyc(1);
    start = 2'b00;
    check("resume_busy", {31'd0, busy[0]}, 32'd1);
    cyc(8);
    check("resume_rem3", {24'd0, rem(0)}, 32'd3);

    // Priority: load with start, then load of 0
    load = 2'b01; start = 2'b01; load_value = 8'd7;
    cyc(1);
    load = 2'b00; start = 2'b00;
    check("prio_idle", {31'd0, busy[0]}, 32'd0);
    check("prio_newcount", {24'd0, rem(0)}, 32'd7);
    load = 2'b01; load_value = 8'd0;
    cyc(1);
    load = 2'b00; start = 2'b01;
    cyc(1);
    start = 2'b00;
    check("zero_no_start", {31'd0, busy[0]}, 32'd0);

`ifdef MULTI_TIMER_WARN_EN
    // Warning window with ch1 at 4, threshold 2
    sync_tick();
    load = 2'b10; load_value = 8'd4;
    cyc(1);
    load = 2'b00; start = 2'b10;
    cyc(1);
    start = 2'b00;
    check("warn_off4", {31'd0, warn[1]}, 32'd0);
    cyc(9);
    check("warn_rem3", {24'd0, rem(1)}, 32'd3);
    check("warn_off3", {31'd0, warn[1]}, 32'd0);
    cyc(10);
    check("warn_on2", {31'd0, warn[1]}, 32'd1);
    cyc(10);
    check("warn_on1", {31'd0, warn[1]}, 32'd1);
    cyc(10);
    check("warn_expire", {31'd0, expire[1]}, 32'd1);
    check("warn_off0", {31'd0, warn[1]}, 32'd0);
`endif

    // Reset mid-run with both channels at 4
    sync_tick();
    load = 2'b11; load_value = 8'd4; periodic = 2'b00;
    cyc(1);
    load = 2'b00; start = 2'b11;
    cyc(1);
    start = 2'b00;
    check("mid_busy", {30'd0, busy}, 32'd3);
    rst = 1'b0;
    #1;
    check("mid_rst_busy", {30'd0, busy}, 32'd0);
    check("mid_rst_remaining", {16'd0, remaining}, 32'd0);
    check("mid_rst_done", {30'd0, done}, 32'd0);
    check("mid_rst_expire", {30'd0, expire}, 32'd0);
    check("mid_rst_tick", {31'd0, tick}, 32'd0);
    cyc(2);
    rst = 1'b1;
    cyc(15);
    check("post_rst_busy", {30'd0, busy}, 32'd0);
    check("post_rst_remaining", {16'd0, remaining}, 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/multi_timer.md
# multi_timer

Parametrised multi-channel countdown timer for the game logic (round clocks, catch windows, turn limits). It derives its own tick period from the clock and tick frequencies, so no constant is pre-computed by hand. It drives `CHANNELS` independent counters from one shared prescaler, each in one-shot or periodic mode. It sits between the game FSM, which issues load, start and stop, and the display and scoring logic, which consume expire, done and remaining.

## Interface
- `CHANNELS`, 2: number of independent timer channels (≥1).
- `CLK_HZ`, 50_000_000: clock frequency in Hz.
- `TICK_HZ`, 1000: count resolution in Hz; `PRESCALE = CLK_HZ / TICK_HZ` (integer, truncating, must be ≥1).
- `CNT_W`, 16: channel counter width; max load is 2^CNT_W − 1 ticks.
- `WARN_TICKS`, 100: warning threshold; used only with `MULTI_TIMER_WARN_EN`.

Ports:
- `clk`  in  1: single clock; every flop is in this domain.
- `rst`  in  1: asynchronous, active-low reset.
- `enable`  in  1: global run; low freezes the prescaler and all counters.
- `load`  in  CHANNELS: per-channel load strobe.
- `load_value`  in  CNT_W: shared load value, sampled on `load`.
- `periodic`  in  CHANNELS: mode, sampled on `load` (1 = periodic, 0 = one-shot).
- `start`  in  CHANNELS: per-channel start or resume strobe.
- `stop`  in  CHANNELS: per-channel pause strobe.
- `tick`  out  1: one-cycle prescaler strobe.
- `expire`  out  CHANNELS: one-cycle pulse when a count reaches 0.
- `done`  out  CHANNELS: sticky; set on one-shot expiry.
- `busy`  out  CHANNELS: channel is in RUN.
- `remaining`  out  CHANNELS*CNT_W: current count; channel i occupies bits [i*CNT_W +: CNT_W].
- `warn`  out  CHANNELS: present only with `MULTI_TIMER_WARN_EN`.

## Operation
- Prescaler:
  - Free-running counter from 0 to `PRESCALE`−1, width clog2(`PRESCALE`), minimum 1.
  - Advances only while `enable`=1.
  - `tick`=1 in the cycle where the counter equals `PRESCALE`−1 and `enable`=1.
  - With `PRESCALE`=1, `tick` follows `enable`.
  - All channels share this prescaler. Phase is not restarted by `start`, so the first decrement occurs 1..`PRESCALE` cycles after start.
- Per-channel registers: count, reload, mode, and state IDLE / RUN / DONE.
- Command priority per channel, evaluated each cycle: `load` > `stop` > `start` > tick decrement.
  - **load** (any state): count ← `load_value`, reload ← `load_value`, mode ← `periodic[i]`, `done` ← 0, state ← IDLE.
  - **stop** in RUN: state ← IDLE, count held. Ignored in IDLE and DONE.
  - **start** in IDLE with count≠0: state ← RUN. Ignored if count=0, in RUN, or in DONE.
  - **tick** in RUN with count>1: count ← count−1.
  - **tick** in RUN with count=1, one-shot: count ← 0, state ← DONE, `done` ← 1, `expire` pulses.
  - **tick** in RUN with count=1, periodic: count ← reload, state stays RUN, `expire` pulses.
- A channel leaves DONE only via `load`.
- Counter arithmetic is unsigned at `CNT_W` bits and never wraps below 0.

## Timing
- Reset values (`rst`=0, asynchronous):
  - prescaler = 0, `tick` = 0.
  - all counts and reloads = 0, all modes one-shot, all states IDLE.
  - `expire`, `done`, `busy`, `remaining`, `warn` = 0.
- Reset asserted mid-run aborts every channel immediately. Nothing resumes after release until a new load and start.
- All outputs are registered:
  - `busy`, `remaining` and `done` reflect a command one cycle after the strobe.
  - `expire` is high for exactly the one cycle after the tick in which count went from 1 to 0 (or to reload).
- Periodic mode with reload L: consecutive `expire` pulses are exactly L*`PRESCALE` cycles apart while `enable` stays high.
- `enable`=0 stalls the prescaler and blocks decrements. `load`, `start` and `stop` are still honoured.
- Strobes are level-sampled each cycle. A strobe held for several cycles acts repeatedly; for example, held `load` keeps the channel in IDLE.

## Configuration
- `MULTI_TIMER_WARN_EN` defined:
  - registered `warn[i]` = 1 when channel i is in RUN and 0 < count ≤ `WARN_TICKS`.
  - `warn[i]` clears on leaving RUN.
- Not defined: the `warn` port and its logic are absent, and `WARN_TICKS` is unused.

## Test plan
Bench parameters: `CHANNELS`=2, `CLK_HZ`=10, `TICK_HZ`=1 (`PRESCALE`=10), `CNT_W`=8, `WARN_TICKS`=2.
- One-shot: load ch0 with 3 and `periodic`=0, then start. Required: `remaining` steps 3→2→1→0 on ticks; a single `expire[0]` pulse; `done[0]`=1 and `busy[0]`=0 afterwards; start in DONE is ignored.
- Periodic: load ch1 with 2 and `periodic`=1, then start. Required: `expire[1]` pulses exactly 20 cycles apart for 4 periods; `remaining` reloads to 2; `done[1]` stays 0.
- Pause: `enable`=0 for 35 cycles mid-count on ch0 (count=5). Required: `remaining` holds 5 and `tick` stays 0. Separately, `stop` then `start` resumes from the held count.
- Priority: `load` and `start` asserted together. Required: the channel is IDLE with the new count. Load 0 then start: required `busy` stays 0.
- Reset: drop `rst` while both channels run at count=4. Required: every output is 0 in the same cycle and stays IDLE after release.
- `MULTI_TIMER_WARN_EN`: count 4 in RUN. Required: `warn` rises when count = 2 and falls at expiry.
